// File: rtl/led_share_arbiter.sv
// Round-robin, time-sliced sharing of the 4-bit LED bank between NREQ status sources.
// A walking-one idle pattern is shown whenever nobody is requesting.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no owner; LED shows the walking-one pattern, rotating per tick
// S_OWN  | source 'owner' drives LED for up to SLOT_TICKS ticks
module led_share_arbiter #(
  parameter int DELAY      = 24000000,
  parameter int NREQ       = 3,
  parameter int SLOT_TICKS = 4
) (
  input  logic                CLOCK_48,
  input  logic                RESET,
  input  logic [NREQ-1:0]     REQ,
  input  logic [4*NREQ-1:0]   PATTERN,
  input  logic [NREQ-1:0]     BLINK,
  output logic [NREQ-1:0]     GRANT,
  output logic [3:0]          LED,
  output logic                TICK
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = (SLOT_TICKS > 0) ? $clog2(SLOT_TICKS + 1) : 1;

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t          state, state_nx;
  logic [24:0]     cnt;
  logic [3:0]      walk, walk_nx;
  logic [PW-1:0]   ptr, ptr_nx;
  logic [PW-1:0]   owner, owner_nx;
  logic [SW-1:0]   slot, slot_nx;
  logic            phase, phase_nx;

  logic [NREQ-1:0] owner_oh;
  logic [3:0]      own_pat;
  logic            own_blink;
  logic            own_req;
  logic            rel_a, rel_b;
  logic [PW-1:0]   ptr_inc;
  logic [NREQ-1:0] cand;
  logic [PW:0]     sel;

  // Lowest offset from 'start' (wrapping mod NREQ) wins; MSB of result flags a hit.
  function automatic logic [PW:0] pick(input logic [NREQ-1:0] req_v,
                                       input logic [PW-1:0]   start);
    logic [PW:0] res;
    logic [PW:0] idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, start} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ))
        idx = idx - (PW+1)'(NREQ);
      if (req_v[idx[PW-1:0]])
        res = {1'b1, idx[PW-1:0]};
    end
    return res;
  endfunction

  assign TICK = (cnt == 25'(DELAY));

  // Free-running prescaler, independent of grant changes
  always_ff @(posedge CLOCK_48) begin
    if (RESET)
      cnt <= '0;
    else if (TICK)
      cnt <= '0;
    else
      cnt <= cnt + 25'd1;
  end

  always_ff @(posedge CLOCK_48) begin
    if (RESET) begin
      state <= S_IDLE;
      walk  <= 4'b0001;
      ptr   <= '0;
      owner <= '0;
      slot  <= '0;
      phase <= 1'b1;
    end else begin
      state <= state_nx;
      walk  <= walk_nx;
      ptr   <= ptr_nx;
      owner <= owner_nx;
      slot  <= slot_nx;
      phase <= phase_nx;
    end
  end

  always_comb begin
    own_pat   = '0;
    own_blink = 1'b0;
    own_req   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == PW'(i)) begin
        own_pat   = PATTERN[4*i +: 4];
        own_blink = BLINK[i];
        own_req   = REQ[i];
      end
    end
  end

  assign owner_oh = NREQ'(1) << owner;
  assign ptr_inc  = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
  assign rel_a    = ~own_req;
  assign rel_b    = TICK && (slot == SW'(SLOT_TICKS - 1));

  always_comb begin
    state_nx = state;
    walk_nx  = walk;
    ptr_nx   = ptr;
    owner_nx = owner;
    slot_nx  = slot;
    phase_nx = phase;
    cand     = '0;
    sel      = '0;
    GRANT    = '0;
    LED      = walk;

    case (state)
      S_IDLE: begin
        if (TICK)
          walk_nx = {walk[2:0], walk[3]};
        if (|REQ) begin
          sel      = pick(REQ, ptr);
          state_nx = S_OWN;
          owner_nx = sel[PW-1:0];
          slot_nx  = '0;
          phase_nx = 1'b1;
        end
      end

      S_OWN: begin
        GRANT = owner_oh;
        LED   = own_blink ? (own_pat & {4{phase}}) : own_pat;
        if (rel_a || rel_b) begin
          // A sole requester whose slot merely expired stays a candidate
          ptr_nx = ptr_inc;
          cand   = rel_a ? (REQ & ~owner_oh) : REQ;
          sel    = pick(cand, ptr_inc);
          if (sel[PW]) begin
            owner_nx = sel[PW-1:0];
            slot_nx  = '0;
            phase_nx = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end else if (TICK) begin
          phase_nx = ~phase;
          slot_nx  = slot + SW'(1);
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_share_arbiter.sv
// Vector-table and scoreboard bench for led_share_arbiter with DELAY=3, NREQ=3, SLOT_TICKS=2.
// Each record holds the inputs for one clock and the outputs expected right after that edge.
module tb_led_share_arbiter;

  logic        CLOCK_48 = 1'b0;
  logic        RESET    = 1'b1;
  logic [2:0]  REQ      = '0;
  logic [11:0] PATTERN  = '0;
  logic [2:0]  BLINK    = '0;
  logic [2:0]  GRANT;
  logic [3:0]  LED;
  logic        TICK;

  led_share_arbiter #(.DELAY(3), .NREQ(3), .SLOT_TICKS(2)) dut (
    .CLOCK_48 (CLOCK_48),
    .RESET    (RESET),
    .REQ      (REQ),
    .PATTERN  (PATTERN),
    .BLINK    (BLINK),
    .GRANT    (GRANT),
    .LED      (LED),
    .TICK     (TICK)
  );

  always #5 CLOCK_48 = ~CLOCK_48;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [11:0] pat;
    logic [2:0]  blk;
    logic [2:0]  eg;
    logic [3:0]  el;
    logic        et;
  } vec_t;

  typedef struct {
    logic [2:0] g;
    logic [3:0] l;
    logic       t;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   c_model = 0;

  // Patterns packed as {P2, P1, P0}
  localparam logic [11:0] PA = {4'b1100, 4'b0101, 4'b1010};
  localparam logic [11:0] PB = {4'b1100, 4'b1111, 4'b1010};
  localparam logic [11:0] PC = {4'b0000, 4'b0101, 4'b1010};

  // Expected TICK follows from a mod-4 cycle count restarted by reset
  function automatic vec_t mk(input logic rst, input logic [2:0] req, input logic [11:0] pat,
                              input logic [2:0] blk, input logic [2:0] eg, input logic [3:0] el);
    vec_t v;
    c_model = rst ? 0 : (c_model + 1) % 4;
    v.rst = rst; v.req = req; v.pat = pat; v.blk = blk;
    v.eg = eg; v.el = el; v.et = (c_model == 3);
    return v;
  endfunction

  function automatic void rep(input int n, input logic [2:0] req, input logic [11:0] pat,
                              input logic [2:0] blk, input logic [2:0] eg, input logic [3:0] el);
    for (int i = 0; i < n; i++)
      vecs.push_back(mk(1'b0, req, pat, blk, eg, el));
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    RESET   = v.rst;
    REQ     = v.req;
    PATTERN = v.pat;
    BLINK   = v.blk;
    sb.push_back('{g: v.eg, l: v.el, t: v.et});
    @(posedge CLOCK_48);
    #1;
    e = sb.pop_front();
    checks++;
    if (GRANT !== e.g) begin
      errors++;
      $display("FAIL grant step %0d: got %b want %b", idx, GRANT, e.g);
    end
    checks++;
    if (LED !== e.l) begin
      errors++;
      $display("FAIL led step %0d: got %b want %b", idx, LED, e.l);
    end
    checks++;
    if (TICK !== e.t) begin
      errors++;
      $display("FAIL tick step %0d: got %b want %b", idx, TICK, e.t);
    end
  endtask

  initial begin
    logic [3:0] w;

    // Reset, then idle walk over four ticks
    vecs.push_back(mk(1'b1, 3'b000, PA, 3'b000, 3'b000, 4'b0001));
    for (int k = 1; k <= 16; k++) begin
      w = 4'b0001 << ((k / 4) % 4);
      vecs.push_back(mk(1'b0, 3'b000, PA, 3'b000, 3'b000, w));
    end
    // Sole requester: slot expiry re-grants without an idle cycle
    rep(8, 3'b001, PA, 3'b000, 3'b001, 4'b1010);
    rep(1, 3'b000, PA, 3'b000, 3'b000, 4'b0001);
    // All three requesting: round-robin, two ticks each
    vecs.push_back(mk(1'b1, 3'b111, PA, 3'b000, 3'b000, 4'b0001));
    rep(7, 3'b111, PA, 3'b000, 3'b001, 4'b1010);
    rep(8, 3'b111, PA, 3'b000, 3'b010, 4'b0101);
    rep(8, 3'b111, PA, 3'b000, 3'b100, 4'b1100);
    rep(1, 3'b111, PA, 3'b000, 3'b001, 4'b1010);
    // Blinking owner toggles per tick, starting lit
    rep(3, 3'b010, PB, 3'b010, 3'b010, 4'b1111);
    rep(4, 3'b010, PB, 3'b010, 3'b010, 4'b0000);
    rep(4, 3'b010, PB, 3'b010, 3'b010, 4'b1111);
    rep(1, 3'b010, PB, 3'b010, 3'b010, 4'b0000);
    // Back to idle, walk resumes from frozen 0001
    rep(3, 3'b000, PA, 3'b000, 3'b000, 4'b0001);
    rep(4, 3'b000, PA, 3'b000, 3'b000, 4'b0010);
    rep(1, 3'b000, PA, 3'b000, 3'b000, 4'b0100);
    // Early drop mid-slot, frozen walk, then ptr favours source 1
    rep(2, 3'b001, PA, 3'b000, 3'b001, 4'b1010);
    rep(1, 3'b000, PA, 3'b000, 3'b000, 4'b0100);
    rep(1, 3'b000, PA, 3'b000, 3'b000, 4'b1000);
    rep(1, 3'b011, PA, 3'b000, 3'b010, 4'b0101);
    // Reach owner 2, then reset mid-grant
    rep(6, 3'b111, PA, 3'b000, 3'b010, 4'b0101);
    rep(2, 3'b111, PA, 3'b000, 3'b100, 4'b1100);
    vecs.push_back(mk(1'b1, 3'b111, PA, 3'b000, 3'b000, 4'b0001));
    rep(2, 3'b111, PA, 3'b000, 3'b001, 4'b1010);

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], i);

    // Drop and slot expiry on the same edge: one release, non-owner pattern change ignored
    for (int i = 0; i < 5; i++)
      run_vec(mk(1'b0, 3'b111, PA, 3'b000, 3'b001, 4'b1010), 1000 + i);
    run_vec(mk(1'b0, 3'b110, PC, 3'b000, 3'b010, 4'b0101), 1005);
    run_vec(mk(1'b0, 3'b000, PC, 3'b000, 3'b000, 4'b0001), 1006);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_share_arbiter.md
Name: led_share_arbiter

Overview:
- Time-sliced round-robin arbiter that shares the 4-bit LED bank between NREQ status requesters, e.g. CNN layer-done, error and busy indicators.
- When no requester is active it drives the walking-one idle pattern.
- Contains its own tick prescaler, so all visible timing is in human-scale ticks.
- Sits at board top level, between the status sources and the LED pins.

Parameters:
DELAY, 24000000, prescaler terminal count; one tick every DELAY+1 clocks (1 s at 24 MHz)
NREQ, 3, number of requesters (2..8)
SLOT_TICKS, 4, maximum ticks a requester holds the LEDs per grant (>=1)

Ports:
CLOCK_48  in  1  system clock (24 MHz)
RESET  in  1  synchronous reset, active-high
REQ  in  NREQ  request per source; level, held while the source wants the LEDs
PATTERN  in  4*NREQ  LED pattern per source; source i uses bits [4i+3:4i]
BLINK  in  NREQ  1 = source i pattern blinks at the tick rate
GRANT  out  NREQ  one-hot owner of the LEDs; 0 when idle
LED  out  4  LED drive; bit n lights LED n
TICK  out  1  one-cycle pulse at the prescaler terminal count

Behaviour:
- Single clock CLOCK_48. RESET is synchronous, active-high, and overrides everything in any state.
- Reset values:
  - cnt=0, TICK=0, state=IDLE, GRANT=0
  - walk=4'b0001, so LED=4'b0001
  - ptr=0, slot=0, phase=1
- Prescaler:
  - cnt (25 bits) increments every clock.
  - When cnt==DELAY: cnt<=0 and TICK=1 for that cycle (combinational from cnt).
- IDLE state:
  - LED=walk.
  - On each TICK, walk rotates left: bit0->1->2->3, bit3->0.
  - When any REQ bit is 1 on a clock edge: go to OWN and grant the first set REQ index searching from ptr upward, wrapping mod NREQ.
  - GRANT is valid the cycle after REQ is first seen; latency 1 clock.
  - On entry to OWN: slot<=0, phase<=1. The walk value is frozen.
- OWN state, owner g:
  - GRANT has bit g set.
  - LED = PATTERN[g] when BLINK[g]=0; LED = PATTERN[g] & {4{phase}} when BLINK[g]=1.
  - LED is combinational from registered g/phase and the live PATTERN input.
  - On each TICK: phase toggles and slot increments.
- Release conditions (evaluated every edge in OWN):
  - (a) REQ[g]==0, or
  - (b) TICK and slot==SLOT_TICKS-1.
  - If (a) and (b) occur together, it is a single release.
- On release:
  - ptr<=(g+1) mod NREQ.
  - Re-arbitrate in the same edge using the new ptr and the current REQ with bit g masked if (a) held. g is not masked if only (b) held, so a sole requester is re-granted back-to-back.
  - If any candidate: stay in OWN with the new owner, slot<=0, phase<=1. There is no idle gap.
  - Otherwise go to IDLE. The walk resumes from its frozen value and the next rotation occurs at the next TICK.
- GRANT is always one-hot or zero, never multi-hot.
- Changes to non-owner PATTERN/BLINK have no effect. A REQ pulse shorter than one clock is not guaranteed to be seen.
- slot width is clog2(SLOT_TICKS+1). Wrap-around is impossible because release happens at SLOT_TICKS-1.
- The prescaler runs freely in both states and is not reset by grant changes.

Test Plan:
(DELAY=3 gives a tick every 4 clocks; SLOT_TICKS=2; NREQ=3.)
- Reset then REQ=000 -> LED=0001 after reset, then 0010, 0100, 1000, 0001 at successive TICKs; TICK pulses at cnt==3 only.
- REQ=001, PATTERN0=1010, BLINK=0 -> GRANT=001 one clock later, LED=1010. After 2 TICKs it is re-granted to 001 with no IDLE cycle and LED stays 1010.
- REQ=111 held -> GRANT sequence 001, 010, 100, 001, each lasting exactly 2 TICKs. LED follows PATTERN0/1/2 accordingly.
- REQ=010, PATTERN1=1111, BLINK=010 -> LED alternates 1111 / 0000 on each TICK, starting at 1111 on grant.
- IDLE walk=0100, REQ=001 asserted then dropped mid-slot -> GRANT=000 the next clock and LED=0100. It becomes 1000 at the following TICK, and ptr=1 so the next grant favours source 1 over 0.
- RESET high mid-OWN with GRANT=100 -> next clock: GRANT=000, LED=0001, cnt=0. With REQ=111 still high after reset, the grant goes to 001 (ptr=0).
